noise_lfsr_checker: RTL and testbench



---
 rtl/noise_pkg.sv | 26 ++
 rtl/noise_lfsr_checker_if.sv | 19 +
 rtl/noise_predict.sv | 17 +
 rtl/noise_lfsr_checker.sv | 156 +++++++++++++++
 tb/tb_noise_lfsr_checker.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noise_pkg.sv
// rtl/noise_pkg.sv - shared constants and types for the 23-bit noise voice
package noise_pkg;

  localparam int LFSR_LEN = 23;
  localparam int FB_TAP_A = 22;
  localparam int FB_TAP_B = 17;

  // Output taps, index 7 down to 0: o[7] is LFSR bit 22 ... o[0] is LFSR bit 2.
  localparam logic [7:0][4:0] OUT_TAPS = {5'd22, 5'd20, 5'd16, 5'd13,
                                          5'd11, 5'd7,  5'd4,  5'd2};

  // The newest history bit (o[0] of the previous step) sits at LFSR bit 3 now.
  localparam int HIST_LAG = 3;

  localparam logic [LFSR_LEN-1:0] NOISE_SEED = 23'b01101110010010000101011;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

  function automatic logic [LFSR_LEN-1:0] lfsr_step(input logic [LFSR_LEN-1:0] s);
    return {s[LFSR_LEN-2:0], s[FB_TAP_A] ^ s[FB_TAP_B]};
  endfunction

endpackage

// File: rtl/noise_lfsr_checker_if.sv
// rtl/noise_lfsr_checker_if.sv - noise sample stream into the checker
interface noise_lfsr_checker_if #(
  parameter int OUTPUT_BITS = 12
);

  logic                   sample_valid;
  logic [OUTPUT_BITS-1:0] din;

  modport master (
    output sample_valid,
    output din
  );

  modport slave (
    input sample_valid,
    input din
  );

endinterface

// File: rtl/noise_predict.sv
// rtl/noise_predict.sv - predicts the next 8-bit noise sample from 23 bits of o[0] history
module noise_predict
  import noise_pkg::*;
(
  input  logic [LFSR_LEN-1:0] hist,
  output logic [7:0]          pred
);

  // Bit 2 of the coming state is the feedback computed three steps ago,
  // whose operands land exactly at hist[FB_TAP_A] and hist[FB_TAP_B].
  assign pred[0] = hist[FB_TAP_A] ^ hist[FB_TAP_B];

  for (genvar k = 1; k < 8; k++) begin : g_tap
    assign pred[k] = hist[int'(OUT_TAPS[k]) - HIST_LAG];
  end

endmodule

// File: rtl/noise_lfsr_checker.sv
// rtl/noise_lfsr_checker.sv - self-synchronising checker for the 23-bit noise generator output
module noise_lfsr_checker
  import noise_pkg::*;
#(
  parameter int OUTPUT_BITS = 12,
  parameter int LOCK_COUNT  = 8,
  parameter int LOSS_COUNT  = 4,
  parameter int ERR_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  noise_lfsr_checker_if.slave  smp,
  input  logic                 clear_err,
  output logic                 locked,
  output logic                 bit_err,
  output logic [7:0]           err_mask,
  output logic [ERR_W-1:0]     err_count,
  output logic                 zero_stuck
);

  localparam logic [4:0] FILL_MAX = 5'(LFSR_LEN);
  localparam logic [7:0] LOCK_N   = 8'(LOCK_COUNT);
  localparam logic [7:0] LOSS_N   = 8'(LOSS_COUNT);

  chk_state_t          state, state_n;
  logic [LFSR_LEN-1:0] hist, hist_n;
  logic [4:0]          fill, fill_n;
  logic [7:0]          match, match_n;
  logic [7:0]          loss, loss_n;
  logic [7:0]          mask_n;
  logic                bit_err_n;
  logic [ERR_W-1:0]    count_n;
  logic                zero_n;

  logic [7:0] obs;
  logic [7:0] pred;
  logic [7:0] mism;
  logic       filled;
  logic       checked;
  logic       bad;
  logic       zero_now;
  logic [7:0] match_inc;
  logic [7:0] loss_inc;

  noise_predict u_predict (
    .hist (hist),
    .pred (pred)
  );

  assign obs       = smp.din[OUTPUT_BITS-1 -: 8];
  assign mism      = pred ^ obs;
  assign bad       = |mism;
  assign filled    = (fill == FILL_MAX);
  assign checked   = smp.sample_valid && filled;
  assign zero_now  = filled && (hist == '0);
  assign match_inc = match + 8'd1;
  assign loss_inc  = loss + 8'd1;
  assign locked    = (state == LOCKED);

  always_comb begin
    state_n   = state;
    hist_n    = hist;
    fill_n    = fill;
    match_n   = match;
    loss_n    = loss;
    mask_n    = err_mask;
    bit_err_n = 1'b0;
    count_n   = err_count;

    if (smp.sample_valid) begin
      hist_n = {hist[LFSR_LEN-2:0], obs[0]};
      if (!filled) begin
        fill_n = fill + 5'd1;
      end
    end

    if (checked) begin
      mask_n = mism;
    end

    unique case (state)
      HUNT: begin
        // An all-zero history predicts itself perfectly, so it must never count toward lock.
        if (zero_now) begin
          match_n = 8'd0;
        end else if (checked) begin
          if (bad) begin
            match_n = 8'd0;
          end else if (match_inc >= LOCK_N) begin
            state_n = LOCKED;
            match_n = 8'd0;
          end else begin
            match_n = match_inc;
          end
        end
      end
      LOCKED: begin
        if (checked) begin
          if (bad) begin
            bit_err_n = 1'b1;
            if (err_count != '1) begin
              count_n = err_count + ERR_W'(1);
            end
            if (loss_inc >= LOSS_N) begin
              state_n = HUNT;
              fill_n  = 5'd0;
              match_n = 8'd0;
              loss_n  = 8'd0;
            end else begin
              loss_n = loss_inc;
            end
          end else begin
            loss_n = 8'd0;
          end
        end
      end
      default: state_n = HUNT;
    endcase

    zero_n = (fill_n == FILL_MAX) && (hist_n == '0);
    if (state == LOCKED && zero_n) begin
      state_n = HUNT;
      match_n = 8'd0;
      loss_n  = 8'd0;
    end

    if (clear_err) begin
      count_n = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      hist       <= '0;
      fill       <= 5'd0;
      match      <= 8'd0;
      loss       <= 8'd0;
      bit_err    <= 1'b0;
      err_mask   <= 8'd0;
      err_count  <= '0;
      zero_stuck <= 1'b0;
    end else begin
      state      <= state_n;
      hist       <= hist_n;
      fill       <= fill_n;
      match      <= match_n;
      loss       <= loss_n;
      bit_err    <= bit_err_n;
      err_mask   <= mask_n;
      err_count  <= count_n;
      zero_stuck <= zero_n;
    end
  end

endmodule

// File: tb/tb_noise_lfsr_checker.sv
// tb/tb_noise_lfsr_checker.sv - self-checking bench for noise_lfsr_checker
module tb_noise_lfsr_checker;

  localparam int OUTPUT_BITS = 12;
  localparam int ERR_W       = 16;
  localparam int LOCK_AT     = 23 + 8;

  logic             clk;
  logic             rst;
  logic             clear_err;
  logic             locked;
  logic             bit_err;
  logic [7:0]       err_mask;
  logic [ERR_W-1:0] err_count;
  logic             zero_stuck;

  int errors = 0;
  int checks = 0;

  logic [22:0] gen;

  noise_lfsr_checker_if #(.OUTPUT_BITS(OUTPUT_BITS)) sig ();

  noise_lfsr_checker #(
    .OUTPUT_BITS (OUTPUT_BITS),
    .LOCK_COUNT  (8),
    .LOSS_COUNT  (4),
    .ERR_W       (ERR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .smp        (sig),
    .clear_err  (clear_err),
    .locked     (locked),
    .bit_err    (bit_err),
    .err_mask   (err_mask),
    .err_count  (err_count),
    .zero_stuck (zero_stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference generator: left-shifting LFSR, feedback bit22^bit17, sample taken before the step.
  function automatic logic [7:0] gen_out(input logic [22:0] g);
    return {g[22], g[20], g[16], g[13], g[11], g[7], g[4], g[2]};
  endfunction

  function automatic logic [22:0] gen_next(input logic [22:0] g);
    return {g[21:0], g[22] ^ g[17]};
  endfunction

  // Corruption that leaves o[0] intact, so the checker's history stays true to the stream.
  function automatic logic [7:0] rand_mask();
    logic [7:0] m;
    m = 8'($urandom_range(1, 127));
    return m << 1;
  endfunction

  task automatic step(input bit v, input bit from_gen, input logic [7:0] val, input bit clr);
    logic [7:0] o;
    @(negedge clk);
    if (v && from_gen) begin
      o   = gen_out(gen) ^ val;
      gen = gen_next(gen);
    end else begin
      o = val;
    end
    sig.sample_valid = v;
    sig.din          = {o, 4'($urandom_range(0, 15))};
    clear_err        = clr;
    @(posedge clk);
    #1;
    sig.sample_valid = 1'b0;
    clear_err        = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    gen = 23'b01101110010010000101011;
  endtask

  task automatic samples_to_lock(output int n);
    n = 0;
    while (!locked && n < 200) begin
      step(1'b1, 1'b1, 8'h00, 1'b0);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({locked, bit_err, err_mask, err_count, zero_stuck} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got locked=%0b bit_err=%0b mask=%h count=%0d zero=%0b, want all 0",
               locked, bit_err, err_mask, err_count, zero_stuck);
    end
    rst = 1'b0;
    gen = 23'b01101110010010000101011;
  endtask

  task automatic test_lock_clean();
    int errs_seen;
    for (int n = 1; n <= LOCK_AT; n++) begin
      step(1'b1, 1'b1, 8'h00, 1'b0);
      if (n == LOCK_AT - 1) begin
        checks++;
        if (locked !== 1'b0) begin
          errors++;
          $display("FAIL early_lock: locked=%0b after sample %0d, want 0", locked, n);
        end
      end
    end
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL lock_point: locked=%0b after sample %0d, want 1", locked, LOCK_AT);
    end
    errs_seen = 0;
    for (int n = 0; n < 10000; n++) begin
      step(1'b1, 1'b1, 8'h00, 1'b0);
      if (bit_err !== 1'b0 || locked !== 1'b1) errs_seen++;
    end
    checks++;
    if (errs_seen != 0) begin
      errors++;
      $display("FAIL clean_stream: %0d samples with bit_err or lost lock, want 0", errs_seen);
    end
    checks++;
    if (err_count !== '0) begin
      errors++;
      $display("FAIL clean_count: err_count=%0d, want 0", err_count);
    end
  endtask

  task automatic test_single_error();
    logic [7:0] m;
    step(1'b1, 1'b1, 8'h08, 1'b0);
    checks++;
    if (bit_err !== 1'b1 || err_mask !== 8'h08 || err_count !== 16'd1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL single_bit3: bit_err=%0b mask=%h count=%0d locked=%0b, want 1 08 1 1",
               bit_err, err_mask, err_count, locked);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 8'h00, 1'b0);
      checks++;
      if (bit_err !== 1'b0) begin
        errors++;
        $display("FAIL pulse_width: bit_err=%0b on clean sample, want 0", bit_err);
      end
      m = rand_mask();
      step(1'b1, 1'b1, m, 1'b0);
      checks++;
      if (bit_err !== 1'b1 || err_mask !== m || err_count !== ERR_W'(2 + i) || locked !== 1'b1) begin
        errors++;
        $display("FAIL random_error: bit_err=%0b mask=%h count=%0d locked=%0b, want 1 %h %0d 1",
                 bit_err, err_mask, err_count, locked, m, 2 + i);
      end
    end
  endtask

  task automatic test_loss_relock();
    int n;
    step(1'b1, 1'b1, 8'h00, 1'b1);
    checks++;
    if (err_count !== '0) begin
      errors++;
      $display("FAIL clear_err: err_count=%0d, want 0", err_count);
    end
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 1'b1, rand_mask(), 1'b0);
      checks++;
      if (err_count !== ERR_W'(k) || locked !== (k < 4)) begin
        errors++;
        $display("FAIL loss_burst: after %0d bad got count=%0d locked=%0b, want %0d %0b",
                 k, err_count, locked, k, (k < 4));
      end
    end
    samples_to_lock(n);
    checks++;
    if (n != LOCK_AT) begin
      errors++;
      $display("FAIL relock_after_loss: relocked after %0d samples, want %0d", n, LOCK_AT);
    end
  endtask

  task automatic test_zero_stuck();
    int lock_seen;
    do_reset();
    for (int n = 1; n <= 23; n++) begin
      step(1'b1, 1'b0, 8'h00, 1'b0);
      if (n == 22) begin
        checks++;
        if (zero_stuck !== 1'b0) begin
          errors++;
          $display("FAIL zero_early: zero_stuck=%0b after sample 22, want 0", zero_stuck);
        end
      end
    end
    checks++;
    if (zero_stuck !== 1'b1) begin
      errors++;
      $display("FAIL zero_flag: zero_stuck=%0b after sample 23, want 1", zero_stuck);
    end
    lock_seen = 0;
    for (int n = 0; n < 1000; n++) begin
      step(1'b1, 1'b0, 8'h00, 1'b0);
      if (locked !== 1'b0 || zero_stuck !== 1'b1) lock_seen++;
    end
    checks++;
    if (lock_seen != 0) begin
      errors++;
      $display("FAIL zero_no_lock: %0d samples locked or zero_stuck low, want 0", lock_seen);
    end
  endtask

  task automatic test_gapped();
    int nvalid;
    int lock_at;
    int cyc;
    do_reset();
    nvalid  = 0;
    lock_at = 0;
    cyc     = 0;
    while (lock_at == 0 && cyc < 300) begin
      if ($urandom_range(0, 99) >= 30) begin
        step(1'b1, 1'b1, 8'h00, 1'b0);
        nvalid++;
      end else begin
        step(1'b0, 1'b0, 8'($urandom), 1'b0);
      end
      if (locked === 1'b1) lock_at = nvalid;
      cyc++;
    end
    checks++;
    if (lock_at != LOCK_AT) begin
      errors++;
      $display("FAIL gapped_lock: locked at sample %0d, want %0d", lock_at, LOCK_AT);
    end
    step(1'b1, 1'b1, rand_mask(), 1'b0);
    checks++;
    if (err_count !== 16'd1) begin
      errors++;
      $display("FAIL gapped_error: err_count=%0d, want 1", err_count);
    end
    step(1'b1, 1'b1, rand_mask(), 1'b1);
    checks++;
    if (err_count !== '0 || bit_err !== 1'b1) begin
      errors++;
      $display("FAIL clear_priority: count=%0d bit_err=%0b, want 0 1", err_count, bit_err);
    end
  endtask

  task automatic test_midstream_reset();
    int n;
    step(1'b1, 1'b1, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'h40, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({locked, bit_err, err_mask, err_count, zero_stuck} !== '0) begin
      errors++;
      $display("FAIL async_reset: got locked=%0b bit_err=%0b mask=%h count=%0d zero=%0b, want all 0",
               locked, bit_err, err_mask, err_count, zero_stuck);
    end
    @(negedge clk);
    rst = 1'b0;
    samples_to_lock(n);
    checks++;
    if (n != LOCK_AT) begin
      errors++;
      $display("FAIL relock_after_reset: relocked after %0d samples, want %0d", n, LOCK_AT);
    end
  endtask

  initial begin
    rst              = 1'b1;
    clear_err        = 1'b0;
    sig.sample_valid = 1'b0;
    sig.din          = '0;
    gen              = 23'b01101110010010000101011;
    test_reset();
    test_lock_clean();
    test_single_error();
    test_loss_relock();
    test_zero_stuck();
    test_gapped();
    test_midstream_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
